// File: rtl/exe_mem_pipe_reg.sv
// EXE/MEM pipeline register chain carrying write-back control, ALU result and destination
// address. It supports flush, stall and shift, and has a combinational forwarding lookup.
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_mem_or_reg,
    input  logic              in_byte_word,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic              out_reg_write,
    output logic              out_mem_or_reg,
    output logic              out_byte_word,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [ADDR_W-1:0] out_wr_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [STAGES-1:0] fwd_stage_hits
);

    logic [STAGES-1:0]             valid_q, valid_d, valid_src;
    logic [STAGES-1:0]             rw_q,    rw_d,    rw_src;
    logic [STAGES-1:0]             mor_q,   mor_d,   mor_src;
    logic [STAGES-1:0]             bw_q,    bw_d,    bw_src;
    logic [STAGES-1:0][DATA_W-1:0] data_q,  data_d,  data_src;
    logic [STAGES-1:0][ADDR_W-1:0] addr_q,  addr_d,  addr_src;

    // Shift sources: stage 0 takes the masked input, every later stage takes its predecessor.
    always_comb begin
        valid_src   = '0;
        rw_src      = '0;
        mor_src     = '0;
        bw_src      = '0;
        data_src    = '0;
        addr_src    = '0;
        valid_src[0] = in_valid;
        rw_src[0]    = in_valid & in_reg_write;
        mor_src[0]   = in_valid & in_mem_or_reg;
        bw_src[0]    = in_valid & in_byte_word;
        data_src[0]  = in_alu_result;
        addr_src[0]  = in_wr_addr;
        for (int k = 1; k < STAGES; k++) begin
            valid_src[k] = valid_q[k-1];
            rw_src[k]    = rw_q[k-1];
            mor_src[k]   = mor_q[k-1];
            bw_src[k]    = bw_q[k-1];
            data_src[k]  = data_q[k-1];
            addr_src[k]  = addr_q[k-1];
        end
    end

    always_comb begin
        valid_d = valid_src;
        rw_d    = rw_src;
        mor_d   = mor_src;
        bw_d    = bw_src;
        data_d  = data_src;
        addr_d  = addr_src;
        if (flush) begin
            valid_d = '0;
            rw_d    = '0;
            mor_d   = '0;
            bw_d    = '0;
            data_d  = '0;
            addr_d  = '0;
        end else if (stall) begin
            valid_d = valid_q;
            rw_d    = rw_q;
            mor_d   = mor_q;
            bw_d    = bw_q;
            data_d  = data_q;
            addr_d  = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rw_q    <= '0;
            mor_q   <= '0;
            bw_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            mor_q   <= mor_d;
            bw_q    <= bw_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid      = valid_q[STAGES-1];
    assign out_reg_write  = rw_q[STAGES-1];
    assign out_mem_or_reg = mor_q[STAGES-1];
    assign out_byte_word  = bw_q[STAGES-1];
    assign out_alu_result = data_q[STAGES-1];
    assign out_wr_addr    = addr_q[STAGES-1];

    // Register 0 is hard-wired, so it never matches; the youngest match wins the data mux.
    always_comb begin
        fwd_stage_hits = '0;
        fwd_data       = '0;
        for (int k = 0; k < STAGES; k++) begin
            fwd_stage_hits[k] = valid_q[k] & rw_q[k] & (addr_q[k] == lookup_addr)
                                & (lookup_addr != '0);
        end
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (fwd_stage_hits[k]) fwd_data = data_q[k];
        end
    end

    assign fwd_hit = |fwd_stage_hits;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg: three instances (STAGES = 3, 2, 1) share one stimulus
// stream, and each check targets the instance whose depth the scenario exercises.
module tb_exe_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_rw, in_mor, in_bw;
    logic [31:0] in_data;
    logic [4:0]  in_addr;
    logic        stall, flush;
    logic [4:0]  lookup;

    logic        v3, rw3, mor3, bw3, hit3;
    logic [31:0] alu3, fd3;
    logic [4:0]  wa3;
    logic [2:0]  sh3;
    logic        v2, rw2, mor2, bw2, hit2;
    logic [31:0] alu2, fd2;
    logic [4:0]  wa2;
    logic [1:0]  sh2;
    logic        v1, rw1, mor1, bw1, hit1;
    logic [31:0] alu1, fd1;
    logic [4:0]  wa1;
    logic [0:0]  sh1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exe_mem_pipe_reg #(.DATA_W(32), .ADDR_W(5), .STAGES(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_write(in_rw),
        .in_mem_or_reg(in_mor), .in_byte_word(in_bw), .in_alu_result(in_data),
        .in_wr_addr(in_addr), .stall(stall), .flush(flush), .out_valid(v3),
        .out_reg_write(rw3), .out_mem_or_reg(mor3), .out_byte_word(bw3),
        .out_alu_result(alu3), .out_wr_addr(wa3), .lookup_addr(lookup),
        .fwd_hit(hit3), .fwd_data(fd3), .fwd_stage_hits(sh3));

    exe_mem_pipe_reg #(.DATA_W(32), .ADDR_W(5), .STAGES(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_write(in_rw),
        .in_mem_or_reg(in_mor), .in_byte_word(in_bw), .in_alu_result(in_data),
        .in_wr_addr(in_addr), .stall(stall), .flush(flush), .out_valid(v2),
        .out_reg_write(rw2), .out_mem_or_reg(mor2), .out_byte_word(bw2),
        .out_alu_result(alu2), .out_wr_addr(wa2), .lookup_addr(lookup),
        .fwd_hit(hit2), .fwd_data(fd2), .fwd_stage_hits(sh2));

    exe_mem_pipe_reg #(.DATA_W(32), .ADDR_W(5), .STAGES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_write(in_rw),
        .in_mem_or_reg(in_mor), .in_byte_word(in_bw), .in_alu_result(in_data),
        .in_wr_addr(in_addr), .stall(stall), .flush(flush), .out_valid(v1),
        .out_reg_write(rw1), .out_mem_or_reg(mor1), .out_byte_word(bw1),
        .out_alu_result(alu1), .out_wr_addr(wa1), .lookup_addr(lookup),
        .fwd_hit(hit1), .fwd_data(fd1), .fwd_stage_hits(sh1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mor, input logic bw,
                         input logic [31:0] d, input logic [4:0] a);
        in_valid = v;
        in_rw    = rw;
        in_mor   = mor;
        in_bw    = bw;
        in_data  = d;
        in_addr  = a;
    endtask

    initial begin
        rst_n  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        lookup = 5'd0;
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        #2;
        chk("rst_out_valid", {31'b0, v3}, 32'd0);
        chk("rst_fwd_hits", {29'b0, sh3}, 32'd0);
        #1 rst_n = 1'b1;

        // Latency: one entry through three stages.
        drive(1, 1, 1, 0, 32'h1234_5678, 5'd7);
        lookup = 5'd7;
        tick();
        chk("lat_d3_e1_valid", {31'b0, v3}, 32'd0);
        chk("lat_d3_e1_hits", {29'b0, sh3}, 32'b001);
        chk("lat_d3_e1_fdata", fd3, 32'h1234_5678);
        chk("lat_d1_e1_valid", {31'b0, v1}, 32'd1);
        chk("lat_d1_e1_alu", alu1, 32'h1234_5678);
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        tick();
        chk("lat_d3_e2_valid", {31'b0, v3}, 32'd0);
        chk("lat_d3_e2_hits", {29'b0, sh3}, 32'b010);
        chk("lat_d2_e2_valid", {31'b0, v2}, 32'd1);
        tick();
        chk("lat_d3_e3_valid", {31'b0, v3}, 32'd1);
        chk("lat_d3_e3_alu", alu3, 32'h1234_5678);
        chk("lat_d3_e3_addr", {27'b0, wa3}, 32'd7);
        chk("lat_d3_e3_ctl", {29'b0, rw3, mor3, bw3}, 32'b110);
        tick();
        chk("lat_d3_e4_valid", {31'b0, v3}, 32'd0);

        // Stall on the two-stage instance.
        drive(1, 1, 0, 0, 32'hA, 5'd1);
        tick();
        drive(1, 1, 0, 0, 32'hB, 5'd2);
        tick();
        chk("stl_pre_alu", alu2, 32'hA);
        stall = 1'b1;
        drive(1, 1, 0, 0, 32'hC, 5'd3);
        tick();
        chk("stl_e1_alu", alu2, 32'hA);
        chk("stl_e1_addr", {27'b0, wa2}, 32'd1);
        tick();
        chk("stl_e2_alu", alu2, 32'hA);
        chk("stl_e2_valid", {31'b0, v2}, 32'd1);
        chk("stl_e2_d3_valid", {31'b0, v3}, 32'd0);
        stall = 1'b0;
        tick();
        chk("stl_rel1_alu", alu2, 32'hB);
        chk("stl_rel1_addr", {27'b0, wa2}, 32'd2);
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        tick();
        chk("stl_rel2_alu", alu2, 32'hC);
        chk("stl_rel2_addr", {27'b0, wa2}, 32'd3);
        tick();
        chk("stl_rel3_valid", {31'b0, v2}, 32'd0);

        // Flush beats stall and drops the presented input.
        drive(1, 1, 0, 0, 32'hD, 5'd9);
        tick();
        drive(1, 1, 0, 0, 32'hE, 5'd10);
        tick();
        lookup = 5'd9;
        #1;
        chk("fl_pre_hit9", {31'b0, hit3}, 32'd1);
        chk("fl_pre_d2_valid", {31'b0, v2}, 32'd1);
        flush = 1'b1;
        stall = 1'b1;
        drive(1, 1, 0, 0, 32'hF, 5'd11);
        tick();
        chk("fl_d3_valid", {31'b0, v3}, 32'd0);
        chk("fl_d2_valid", {31'b0, v2}, 32'd0);
        for (int a = 9; a <= 11; a++) begin
            lookup = 5'(a);
            #1;
            chk("fl_hit_d3", {31'b0, hit3}, 32'd0);
            chk("fl_hit_d2", {31'b0, hit2}, 32'd0);
        end
        flush = 1'b0;
        stall = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_after_valid", {31'b0, v3}, 32'd0);
        end

        // Forwarding priority: youngest matching stage supplies the data.
        drive(1, 1, 0, 0, 32'h11, 5'd5);
        tick();
        drive(1, 1, 0, 0, 32'h33, 5'd6);
        tick();
        drive(1, 1, 0, 0, 32'h22, 5'd5);
        tick();
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        lookup = 5'd5;
        #1;
        chk("fw_d3_hit", {31'b0, hit3}, 32'd1);
        chk("fw_d3_data", fd3, 32'h22);
        chk("fw_d3_hits", {29'b0, sh3}, 32'b101);
        chk("fw_d3_out_alu", alu3, 32'h11);
        chk("fw_d2_hits", {30'b0, sh2}, 32'b01);
        chk("fw_d1_data", fd1, 32'h22);
        lookup = 5'd6;
        #1;
        chk("fw_d3_hits6", {29'b0, sh3}, 32'b010);
        chk("fw_d3_data6", fd3, 32'h33);
        lookup = 5'd0;
        #1;
        chk("fw_d3_hit0", {31'b0, hit3}, 32'd0);

        // Control masking and register 0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 1, 1, 1, 32'h44, 5'd4);
        tick();
        chk("mk_d1_valid", {31'b0, v1}, 32'd0);
        chk("mk_d1_ctl", {29'b0, rw1, mor1, bw1}, 32'b000);
        chk("mk_d1_alu", alu1, 32'h44);
        chk("mk_d1_addr", {27'b0, wa1}, 32'd4);
        drive(1, 1, 0, 0, 32'h55, 5'd0);
        tick();
        chk("mk_d1_r0_valid", {31'b0, v1}, 32'd1);
        chk("mk_d1_r0_rw", {31'b0, rw1}, 32'd1);
        chk("mk_d1_r0_alu", alu1, 32'h55);
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        lookup = 5'd4;
        #1;
        chk("mk_d3_hit4", {31'b0, hit3}, 32'd0);
        lookup = 5'd0;
        #1;
        chk("mk_d3_hit0", {31'b0, hit3}, 32'd0);
        chk("mk_d3_data0", fd3, 32'h0);
        chk("mk_d1_hit0", {31'b0, hit1}, 32'd0);

        // Asynchronous reset mid-stream, then a fresh entry.
        drive(1, 1, 1, 1, 32'h100, 5'd8);
        tick();
        drive(1, 1, 1, 1, 32'h200, 5'd9);
        tick();
        drive(1, 1, 1, 1, 32'h300, 5'd10);
        tick();
        lookup = 5'd9;
        #1;
        chk("ar_pre_valid", {31'b0, v3}, 32'd1);
        chk("ar_pre_alu", alu3, 32'h100);
        chk("ar_pre_hit", {31'b0, hit3}, 32'd1);
        drive(1, 1, 0, 0, 32'h400, 5'd11);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, v3}, 32'd0);
        chk("ar_alu", alu3, 32'h0);
        chk("ar_ctl", {29'b0, rw3, mor3, bw3}, 32'b000);
        chk("ar_hit", {31'b0, hit3}, 32'd0);
        chk("ar_fdata", fd3, 32'h0);
        chk("ar_hits", {29'b0, sh3}, 32'd0);
        chk("ar_d1_valid", {31'b0, v1}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        tick();
        chk("ar_post_e2_valid", {31'b0, v3}, 32'd0);
        tick();
        chk("ar_post_e3_valid", {31'b0, v3}, 32'd1);
        chk("ar_post_e3_alu", alu3, 32'h400);
        chk("ar_post_e3_addr", {27'b0, wa3}, 32'd11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
